// File: rtl/ternary_neuron_array.sv
// ternary_neuron_array: N_CH parallel multiplier-free neurons. Each beat carries
// one signed activation and a ternary weight per channel; at vector close every
// channel applies optional ReLU, an arithmetic shift and output saturation, and
// the packed result vector is held on a valid/ready port until it is taken.
module ternary_neuron_array #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned VEC_LEN = 16,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned OUT_W   = 8,
   parameter int unsigned SHIFT   = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [DATA_W-1:0]          in_data,
   input  logic        [2*N_CH-1:0]          in_w,
   input  logic                              in_last,
   input  logic                              relu_en,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic        [N_CH*OUT_W-1:0]      out_data,
   output logic        [$clog2(VEC_LEN+1)-1:0] out_beats,
   output logic                              w_err
);

   localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
   localparam int unsigned SUM_W = ACC_W + 1;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   // OUT_W bounds expressed at accumulator width for signed comparison
   localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic signed [ACC_W-1:0] acc_q   [N_CH];
   logic signed [ACC_W-1:0] acc_upd [N_CH];
   logic signed [SUM_W-1:0] sum     [N_CH];
   logic signed [ACC_W-1:0] relu_v  [N_CH];
   logic signed [ACC_W-1:0] shr     [N_CH];
   logic [N_CH*OUT_W-1:0]   res_packed;
   logic [CNT_W-1:0]        cnt_q;
   logic                    any_rsv;
   logic                    accept;
   logic                    close;

   assign accept = in_valid & in_ready;
   assign close  = accept & (in_last | (cnt_q == CNT_W'(VEC_LEN - 1)));

   // Per-channel saturating add/sub/skip and the closing post-processing chain
   always_comb begin
      any_rsv    = 1'b0;
      res_packed = '0;
      for (int c = 0; c < N_CH; c++) begin
         sum[c] = SUM_W'(acc_q[c]);
         case (in_w[2*c +: 2])
            2'b01:   sum[c] = sum[c] + SUM_W'(in_data);
            2'b11:   sum[c] = sum[c] - SUM_W'(in_data);
            2'b10:   any_rsv = 1'b1;
            default: ;
         endcase
         // one guard bit is enough because ACC_W >= DATA_W+1
         if (sum[c][SUM_W-1] != sum[c][SUM_W-2])
            acc_upd[c] = sum[c][SUM_W-1] ? ACC_MIN : ACC_MAX;
         else
            acc_upd[c] = sum[c][ACC_W-1:0];
         relu_v[c] = (relu_en && acc_upd[c][ACC_W-1]) ? '0 : acc_upd[c];
         shr[c]    = relu_v[c] >>> SHIFT;
         if (shr[c] > OUT_MAX_A)
            res_packed[c*OUT_W +: OUT_W] = {1'b0, {(OUT_W-1){1'b1}}};
         else if (shr[c] < OUT_MIN_A)
            res_packed[c*OUT_W +: OUT_W] = {1'b1, {(OUT_W-1){1'b0}}};
         else
            res_packed[c*OUT_W +: OUT_W] = shr[c][OUT_W-1:0];
      end
   end

   // Next-state: close a vector from ACC, release it on handshake from EMIT
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACC:  if (close)     state_d = ST_EMIT;
         ST_EMIT: if (out_ready) state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
   end

   // State register with registered handshake outputs derived from next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ACC;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == ST_ACC);
         out_valid <= (state_d == ST_EMIT);
      end
   end

   // Accumulators, beat counter, result latch and sticky reserved-code flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
         cnt_q     <= '0;
         out_data  <= '0;
         out_beats <= '0;
         w_err     <= 1'b0;
      end else if (accept) begin
         w_err <= w_err | any_rsv;
         if (close) begin
            for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
            cnt_q     <= '0;
            out_data  <= res_packed;
            out_beats <= cnt_q + CNT_W'(1);
         end else begin
            for (int c = 0; c < N_CH; c++) acc_q[c] <= acc_upd[c];
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ternary_neuron_array.sv
// Directed bench for ternary_neuron_array with default parameters.
module tb_ternary_neuron_array;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_data;
   logic [7:0]        in_w;
   logic              in_last;
   logic              relu_en;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [4:0]        out_beats;
   logic              w_err;

   int n_cmp  = 0;
   int n_fail = 0;

   ternary_neuron_array dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_w(in_w), .in_last(in_last), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_beats(out_beats), .w_err(w_err)
   );

   always #5 clk = ~clk;

   // drive one beat, waiting (bounded) for in_ready; returns #1 after the accepting edge
   task automatic send_beat(input logic signed [7:0] x, input logic [7:0] w,
                            input logic last, input logic relu);
      int waited;
      in_data  = x;
      in_w     = w;
      in_last  = last;
      relu_en  = relu;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      relu_en  = 1'b0;
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_cmp++; if (out_beats !== 5'd0) begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", out_beats); end
      n_cmp++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL reset_w_err: got %b want 0", w_err); end
   endtask

   // ch0=+1 ch1=-1 ch2=0 ch3=+1, three beats of 10
   task automatic test_basic_mix();
      send_beat(8'sd10, 8'b01_00_11_01, 1'b0, 1'b0);
      send_beat(8'sd10, 8'b01_00_11_01, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      send_beat(8'sd10, 8'b01_00_11_01, 1'b1, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 32'h1E00E21E) begin n_fail++; $display("FAIL basic_data: got %h want 1e00e21e", out_data); end
      n_cmp++; if (out_beats !== 5'd3) begin n_fail++; $display("FAIL basic_beats: got %0d want 3", out_beats); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
      take_result();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_relu();
      send_beat(8'sd10, 8'b01_00_11_01, 1'b0, 1'b0);
      send_beat(8'sd10, 8'b01_00_11_01, 1'b0, 1'b0);
      send_beat(8'sd10, 8'b01_00_11_01, 1'b1, 1'b1);
      n_cmp++; if (out_data !== 32'h1E00001E) begin n_fail++; $display("FAIL relu_data: got %h want 1e00001e", out_data); end
      take_result();
   endtask

   task automatic test_sat_autoclose();
      for (int i = 0; i < 15; i++) send_beat(8'sd127, 8'h55, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL auto_early_valid: got %b want 0", out_valid); end
      send_beat(8'sd127, 8'h55, 1'b0, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL auto_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL sat_pos_data: got %h want 7f7f7f7f", out_data); end
      n_cmp++; if (out_beats !== 5'd16) begin n_fail++; $display("FAIL auto_beats: got %0d want 16", out_beats); end
      take_result();
      for (int i = 0; i < 16; i++) send_beat(-8'sd128, 8'h55, 1'b0, 1'b0);
      n_cmp++; if (out_data !== 32'h80808080) begin n_fail++; $display("FAIL sat_neg_data: got %h want 80808080", out_data); end
      n_cmp++; if (out_beats !== 5'd16) begin n_fail++; $display("FAIL auto_neg_beats: got %0d want 16", out_beats); end
      take_result();
   endtask

   task automatic test_backpressure();
      send_beat(8'sd7, 8'b00_00_00_01, 1'b1, 1'b0);
      // upstream presents a new beat while the result is stalled
      in_data = 8'sd100; in_w = 8'b00_00_00_01; in_last = 1'b1; in_valid = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         n_cmp++; if (out_data !== 32'h00000007) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h want 00000007", i, out_data); end
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      // held beat accepted now into a fresh accumulator
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      n_cmp++; if (out_data !== 32'h00000064) begin n_fail++; $display("FAIL bp_next_data: got %h want 00000064", out_data); end
      n_cmp++; if (out_beats !== 5'd1) begin n_fail++; $display("FAIL bp_next_beats: got %0d want 1", out_beats); end
      take_result();
   endtask

   task automatic test_reserved();
      send_beat(8'sd50, 8'b00_10_00_01, 1'b0, 1'b0);
      send_beat(8'sd50, 8'b00_10_00_01, 1'b1, 1'b0);
      n_cmp++; if (out_data !== 32'h00000064) begin n_fail++; $display("FAIL rsv_data: got %h want 00000064", out_data); end
      n_cmp++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL rsv_w_err: got %b want 1", w_err); end
      take_result();
      send_beat(8'sd1, 8'b00_00_00_01, 1'b1, 1'b0);
      n_cmp++; if (out_data !== 32'h00000001) begin n_fail++; $display("FAIL rsv_next_data: got %h want 00000001", out_data); end
      n_cmp++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL rsv_sticky: got %b want 1", w_err); end
      take_result();
   endtask

   task automatic test_mid_reset();
      send_beat(8'sd20, 8'b00_00_00_01, 1'b0, 1'b0);
      send_beat(8'sd20, 8'b00_00_00_01, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mrst_out_data: got %h want 0", out_data); end
      n_cmp++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL mrst_w_err: got %b want 0", w_err); end
      n_cmp++; if (out_beats !== 5'd0) begin n_fail++; $display("FAIL mrst_out_beats: got %0d want 0", out_beats); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      // input changes without in_valid must not disturb the accumulators
      in_data = 8'sd99; in_w = 8'hFF; in_last = 1'b1;
      @(posedge clk); #1;
      in_data = -8'sd77; in_w = 8'hAA;
      @(posedge clk); #1;
      in_last = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
      n_cmp++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL idle_w_err: got %b want 0", w_err); end
      send_beat(8'sd5, 8'b00_00_00_01, 1'b1, 1'b0);
      n_cmp++; if (out_data !== 32'h00000005) begin n_fail++; $display("FAIL mrst_data: got %h want 00000005", out_data); end
      n_cmp++; if (out_beats !== 5'd1) begin n_fail++; $display("FAIL mrst_beats: got %0d want 1", out_beats); end
      take_result();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_w = '0;
      in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
      #12 rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic_mix();
      test_relu();
      test_sat_autoclose();
      test_backpressure();
      test_reserved();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
